// File: rtl/fifo_pkg.sv
// Shared widths, result-state encoding and ack/err decode for the FIFO pointer/flag controller.
package fifo_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    WRITE  = 3'b001,
    WR_ERR = 3'b010,
    READ   = 3'b011,
    RD_ERR = 3'b100,
    WR_RD  = 3'b101
  } state_t;

  typedef struct packed {
    logic wr_ack;
    logic wr_err;
    logic rd_ack;
    logic rd_err;
  } result_t;

  // side_op marks that the non-failing half of a simultaneous request was taken
  function automatic result_t decode_result(input state_t s, input logic side_op);
    result_t r;
    r        = '0;
    r.wr_ack = (s == WRITE) || (s == WR_RD) || ((s == RD_ERR) && side_op);
    r.rd_ack = (s == READ)  || (s == WR_RD) || ((s == WR_ERR) && side_op);
    r.wr_err = (s == WR_ERR);
    r.rd_err = (s == RD_ERR);
    return r;
  endfunction

endpackage

// File: rtl/fifo_controller_if.sv
// Request/response bundle between a FIFO requester and the pointer/flag controller.
interface fifo_controller_if;
  import fifo_pkg::*;

  logic              wr_en;
  logic              rd_en;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  data_count;
  logic              full;
  logic              empty;
  logic              wr_ack;
  logic              wr_err;
  logic              rd_ack;
  logic              rd_err;

  modport master (
    output wr_en, rd_en,
    input  we, wr_addr, rd_addr, data_count, full, empty,
    input  wr_ack, wr_err, rd_ack, rd_err
  );

  modport slave (
    input  wr_en, rd_en,
    output we, wr_addr, rd_addr, data_count, full, empty,
    output wr_ack, wr_err, rd_ack, rd_err
  );
endinterface

// File: rtl/fifo_ns.sv
// Combinational next-state, next-pointer and next-count calculation for the FIFO controller.
module fifo_ns
  import fifo_pkg::*;
(
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] head,
  input  logic [ADDR_W-1:0] tail,
  input  logic [CNT_W-1:0]  data_count,
  output state_t            state_nxt,
  output logic              side_nxt,
  output logic [ADDR_W-1:0] head_nxt,
  output logic [ADDR_W-1:0] tail_nxt,
  output logic [CNT_W-1:0]  count_nxt
);

  logic is_full;
  logic is_empty;
  logic do_wr;
  logic do_rd;

  assign is_full  = (data_count == CNT_W'(DEPTH));
  assign is_empty = (data_count == '0);
  assign do_wr    = wr_en && !is_full;
  assign do_rd    = rd_en && !is_empty;

  // Error states win; full and empty are exclusive so at most one error fires
  always_comb begin
    state_nxt = IDLE;
    side_nxt  = 1'b0;
    if (wr_en && is_full) begin
      state_nxt = WR_ERR;
      side_nxt  = do_rd;
    end else if (rd_en && is_empty) begin
      state_nxt = RD_ERR;
      side_nxt  = do_wr;
    end else if (do_wr && do_rd) begin
      state_nxt = WR_RD;
    end else if (do_wr) begin
      state_nxt = WRITE;
    end else if (do_rd) begin
      state_nxt = READ;
    end
  end

  always_comb begin
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = data_count;
    if (do_wr) tail_nxt = tail + ADDR_W'(1);
    if (do_rd) head_nxt = head + ADDR_W'(1);
    if (do_wr && !do_rd)      count_nxt = data_count + CNT_W'(1);
    else if (do_rd && !do_wr) count_nxt = data_count - CNT_W'(1);
  end

endmodule

// File: rtl/fifo_controller.sv
// Pointer/flag controller for an 8-entry synchronous FIFO: holds head/tail/count and
// the one-cycle result state, and decodes write enable, flags and ack/err outputs.
module fifo_controller
  import fifo_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  fifo_controller_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic              side_op;
  logic              side_nxt;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W-1:0] head_nxt;
  logic [ADDR_W-1:0] tail_nxt;
  logic [CNT_W-1:0]  data_count;
  logic [CNT_W-1:0]  count_nxt;
  result_t           result;

  fifo_ns u_ns (
    .wr_en      (bus.wr_en),
    .rd_en      (bus.rd_en),
    .head       (head),
    .tail       (tail),
    .data_count (data_count),
    .state_nxt  (state_nxt),
    .side_nxt   (side_nxt),
    .head_nxt   (head_nxt),
    .tail_nxt   (tail_nxt),
    .count_nxt  (count_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      side_op    <= 1'b0;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
    end else begin
      state      <= state_nxt;
      side_op    <= side_nxt;
      head       <= head_nxt;
      tail       <= tail_nxt;
      data_count <= count_nxt;
    end
  end

  assign result = decode_result(state, side_op);

  assign bus.full       = (data_count == CNT_W'(DEPTH));
  assign bus.empty      = (data_count == '0);
  assign bus.we         = bus.wr_en && !bus.full;
  assign bus.wr_addr    = tail;
  assign bus.rd_addr    = head;
  assign bus.data_count = data_count;
  assign bus.wr_ack     = result.wr_ack;
  assign bus.wr_err     = result.wr_err;
  assign bus.rd_ack     = result.rd_ack;
  assign bus.rd_err     = result.rd_err;

endmodule

// File: tb/tb_fifo_controller.sv
// Scoreboard bench for fifo_controller: driver pushes expected post-edge results, monitor checks.
module tb_fifo_controller;
  import fifo_pkg::*;

  logic clk;
  logic reset_n;

  fifo_controller_if bus ();

  fifo_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int wa;
    int werr;
    int ra;
    int rerr;
    int cnt;
    int head;
    int tail;
    int full;
    int empty;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_cnt  = 0;
  int m_head = 0;
  int m_tail = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Drive one request at the falling edge; model the result of the next rising edge
  task automatic step(input int w, input int r);
    exp_t e;
    int   do_wr;
    int   do_rd;
    @(negedge clk);
    bus.wr_en = 1'(w);
    bus.rd_en = 1'(r);
    do_wr  = (w != 0 && m_cnt != DEPTH) ? 1 : 0;
    do_rd  = (r != 0 && m_cnt != 0) ? 1 : 0;
    e.wa   = do_wr;
    e.ra   = do_rd;
    e.werr = (w != 0 && m_cnt == DEPTH) ? 1 : 0;
    e.rerr = (r != 0 && m_cnt == 0) ? 1 : 0;
    #1;
    chk("we", int'(bus.we), do_wr);
    chk("wr_addr_pre", int'(bus.wr_addr), m_tail);
    m_cnt  = m_cnt + do_wr - do_rd;
    m_tail = (m_tail + do_wr) % DEPTH;
    m_head = (m_head + do_rd) % DEPTH;
    e.cnt   = m_cnt;
    e.head  = m_head;
    e.tail  = m_tail;
    e.full  = (m_cnt == DEPTH) ? 1 : 0;
    e.empty = (m_cnt == 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count"}, int'(bus.data_count), 0);
    chk({tag, "_empty"}, int'(bus.empty), 1);
    chk({tag, "_full"},  int'(bus.full), 0);
    chk({tag, "_head"},  int'(bus.rd_addr), 0);
    chk({tag, "_tail"},  int'(bus.wr_addr), 0);
    chk({tag, "_acks"},  int'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}), 0);
  endtask

  // Monitor: every rising edge with a pending expectation, compare after settling
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_ack", int'(bus.wr_ack), e.wa);
        chk("wr_err", int'(bus.wr_err), e.werr);
        chk("rd_ack", int'(bus.rd_ack), e.ra);
        chk("rd_err", int'(bus.rd_err), e.rerr);
        chk("count",  int'(bus.data_count), e.cnt);
        chk("rd_addr", int'(bus.rd_addr), e.head);
        chk("wr_addr", int'(bus.wr_addr), e.tail);
        chk("full",   int'(bus.full), e.full);
        chk("empty",  int'(bus.empty), e.empty);
      end
    end
  end

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Fill to full, then one rejected write
    for (int i = 0; i < DEPTH; i++) step(1, 0);
    settle();
    chk("fill_count", int'(bus.data_count), 8);
    chk("fill_full", int'(bus.full), 1);
    chk("fill_tail_wrap", int'(bus.wr_addr), 0);
    step(1, 0);
    settle();
    chk("ovf_wr_err", int'(bus.wr_err), 1);
    chk("ovf_wr_ack", int'(bus.wr_ack), 0);
    chk("ovf_count", int'(bus.data_count), 8);

    // Drain to empty, then one rejected read
    for (int i = 0; i < DEPTH; i++) step(0, 1);
    settle();
    chk("drain_empty", int'(bus.empty), 1);
    chk("drain_head_wrap", int'(bus.rd_addr), 0);
    step(0, 1);
    settle();
    chk("udf_rd_err", int'(bus.rd_err), 1);
    chk("udf_head", int'(bus.rd_addr), 0);

    // Simultaneous at empty: read rejected, write taken
    step(1, 1);
    settle();
    chk("sim_empty_rd_err", int'(bus.rd_err), 1);
    chk("sim_empty_wr_ack", int'(bus.wr_ack), 1);
    chk("sim_empty_count", int'(bus.data_count), 1);

    // Simultaneous at count=3: both pointers advance, count held
    step(1, 0);
    step(1, 0);
    step(1, 1);
    settle();
    chk("sim3_wr_ack", int'(bus.wr_ack), 1);
    chk("sim3_rd_ack", int'(bus.rd_ack), 1);
    chk("sim3_count", int'(bus.data_count), 3);
    chk("sim3_head", int'(bus.rd_addr), 1);
    chk("sim3_tail", int'(bus.wr_addr), 4);

    // Simultaneous at full: write rejected, read taken
    for (int i = 0; i < 5; i++) step(1, 0);
    step(1, 1);
    settle();
    chk("sim_full_wr_err", int'(bus.wr_err), 1);
    chk("sim_full_rd_ack", int'(bus.rd_ack), 1);
    chk("sim_full_count", int'(bus.data_count), 7);

    // Mid-operation asynchronous reset at count=5
    step(0, 1);
    step(0, 1);
    step(0, 0);
    settle();
    chk("pre_rst_count", int'(bus.data_count), 5);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_state("midrst");
    m_cnt  = 0;
    m_head = 0;
    m_tail = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0);
    settle();
    chk("post_rst_count", int'(bus.data_count), 1);

    for (int i = 0; i < 2000; i++) step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    settle();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
